// File: rtl/aes_pkg.sv
// Shared AES types, constants and helpers used by the key schedule, the
// inverse round and the round controller.
package aes_pkg;

   typedef logic [31:0]       word_t;
   typedef logic [0:15][7:0]  state_t;

   localparam int NR = 10;
   localparam int NK = 4;
   localparam int NW = NK * (NR + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      READY  = 2'd2
   } ks_state_e;

   // Round constant for key-word group n = i/4 (valid for n = 1..10).
   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational byte substitution.
module aes_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 key expansion, one word per clock into a 44-word flop store,
// with a registered round-key read port indexed by round number.
//
// state  | meaning
// IDLE   | no key loaded since reset
// EXPAND | generating w[4..43], one word per clock
// READY  | all 44 words valid, key_ready high
module aes_inv_key_sched
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             n_rst,
   input  logic             key_load,
   input  word_t [0:3]      key_in,
   input  logic [3:0]       round_sel,
   output word_t [0:3]      round_key,
   output logic             key_ready,
   output logic             busy
);

   ks_state_e   r_state;
   ks_state_e   w_state_nxt;
   logic [5:0]  r_idx;
   word_t       r_w [0:NW-1];

   logic [5:0]  w_i;
   logic        w_last;
   word_t       w_prev;
   word_t       w_back4;
   word_t       w_rot;
   word_t       w_sub;
   word_t       w_temp;
   word_t       w_new;
   logic        w_sel_ok;
   logic [5:0]  w_base;

   // Clamp keeps the look-back reads in range while not expanding.
   assign w_i     = (r_idx < 6'd4) ? 6'd4 : r_idx;
   assign w_last  = (r_idx == 6'(NW - 1));
   assign w_prev  = r_w[w_i - 6'd1];
   assign w_back4 = r_w[w_i - 6'd4];
   assign w_rot   = {w_prev[23:0], w_prev[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_subword
      aes_sbox u_sbox (
         .i_byte (w_rot[8*b +: 8]),
         .o_byte (w_sub[8*b +: 8])
      );
   end

   assign w_temp = (w_i[1:0] == 2'd0) ? (w_sub ^ {rcon(w_i[5:2]), 24'h0}) : w_prev;
   assign w_new  = w_back4 ^ w_temp;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (key_load) begin
         w_state_nxt = EXPAND;
      end else begin
         case (r_state)
            EXPAND:  if (w_last) w_state_nxt = READY;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_comb begin
      busy      = (r_state == EXPAND);
      key_ready = (r_state == READY);
   end

   // A key_load in any state restarts; stale w4..w43 are simply overwritten.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_idx <= 6'd0;
         for (int k = 0; k < NW; k++) r_w[k] <= '0;
      end else if (key_load) begin
         r_w[0] <= key_in[0];
         r_w[1] <= key_in[1];
         r_w[2] <= key_in[2];
         r_w[3] <= key_in[3];
         r_idx  <= 6'd4;
      end else if (r_state == EXPAND) begin
         r_w[r_idx] <= w_new;
         if (!w_last) r_idx <= r_idx + 6'd1;
      end
   end

   assign w_sel_ok = (round_sel <= 4'(NR));
   assign w_base   = w_sel_ok ? {round_sel, 2'b00} : 6'd0;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         round_key <= '0;
      end else if (w_sel_ok) begin
         round_key <= {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
      end else begin
         round_key <= '0;
      end
   end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using FIPS-197 A.1 and all-zero key vectors.
module tb_aes_inv_key_sched;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic          key_load = 1'b0;
   logic [127:0]  key_in = '0;
   logic [3:0]    round_sel = '0;
   logic [127:0]  round_key;
   logic          key_ready;
   logic          busy;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [127:0] KA = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   logic [127:0] rk_a [0:10];

   always #5 clk = ~clk;

   aes_inv_key_sched dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .key_load  (key_load),
      .key_in    (key_in),
      .round_sel (round_sel),
      .round_key (round_key),
      .key_ready (key_ready),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rk_a = '{
         128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
         128'ha0fafe17_88542cb1_23a33939_2a6c7605,
         128'hf2c295f2_7a96b943_5935807a_7359f67f,
         128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
         128'hef44a541_a8525b7f_b671253b_db0bad00,
         128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
         128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
         128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
         128'head27321_b58dbad2_312bf560_7f8d292f,
         128'hac7766f3_19fadc21_28d12941_575c006e,
         128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
      };

      // Reset then idle
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
      repeat (5) tick();
      chk("t1_ready", {127'd0, key_ready}, 128'd0);
      chk("t1_busy", {127'd0, busy}, 128'd0);
      for (int r = 0; r <= 10; r++) begin
         round_sel = 4'(r);
         tick();
         chk("t1_rk", round_key, 128'd0);
      end

      // FIPS-197 A.1 expansion: busy for 40 cycles, ready 40 edges after load
      key_in = KA;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      chk("t2_busy0", {127'd0, busy}, 128'd1);
      chk("t2_ready0", {127'd0, key_ready}, 128'd0);
      for (int k = 1; k < 40; k++) begin
         tick();
         chk("t2_busy", {127'd0, busy}, 128'd1);
         chk("t2_ready", {127'd0, key_ready}, 128'd0);
      end
      tick();
      chk("t2_ready40", {127'd0, key_ready}, 128'd1);
      chk("t2_busy40", {127'd0, busy}, 128'd0);
      round_sel = 4'd1;
      tick();
      chk("t2_rk1", round_key, rk_a[1]);

      // Inverse-order sweep, one-cycle latency
      for (int r = 10; r >= 0; r--) begin
         round_sel = 4'(r);
         if (r < 10) chk("t3_hold", round_key, rk_a[r + 1]);
         tick();
         chk("t3_rk", round_key, rk_a[r]);
      end

      // Out-of-range selects
      round_sel = 4'd11;
      tick();
      chk("t4_sel11", round_key, 128'd0);
      round_sel = 4'd10;
      tick();
      chk("t4_sel10", round_key, rk_a[10]);
      round_sel = 4'd15;
      tick();
      chk("t4_sel15", round_key, 128'd0);

      // Restart mid-expansion with the all-zero key
      key_in = KA;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      chk("t5_ready_drop", {127'd0, key_ready}, 128'd0);
      repeat (19) tick();
      key_in = '0;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      chk("t5_busy0", {127'd0, busy}, 128'd1);
      for (int k = 1; k < 40; k++) begin
         tick();
         chk("t5_busy", {127'd0, busy}, 128'd1);
         chk("t5_ready", {127'd0, key_ready}, 128'd0);
      end
      tick();
      chk("t5_ready40", {127'd0, key_ready}, 128'd1);
      round_sel = 4'd1;
      tick();
      chk("t5_rk1", round_key, 128'h62636363_62636363_62636363_62636363);
      round_sel = 4'd10;
      tick();
      chk("t5_rk10", round_key, 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e);
      round_sel = 4'd0;
      tick();
      chk("t5_rk0", round_key, 128'd0);

      // Async reset mid-expansion
      key_in = KA;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      repeat (14) tick();
      chk("t6_pre_rk", round_key, KA);
      #3 n_rst = 1'b0;
      #1;
      chk("t6_busy", {127'd0, busy}, 128'd0);
      chk("t6_ready", {127'd0, key_ready}, 128'd0);
      chk("t6_rk", round_key, 128'd0);
      #2 n_rst = 1'b1;
      repeat (45) tick();
      chk("t6_idle_busy", {127'd0, busy}, 128'd0);
      chk("t6_idle_ready", {127'd0, key_ready}, 128'd0);
      round_sel = 4'd1;
      tick();
      chk("t6_rk1_clear", round_key, 128'd0);

      // Fresh load after reset completes normally
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      repeat (40) tick();
      chk("t6_reload_ready", {127'd0, key_ready}, 128'd1);
      round_sel = 4'd10;
      tick();
      chk("t6_reload_rk10", round_key, rk_a[10]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
